// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_pkg
// Description : Shared types and constants for the shift/rotate sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_seq_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int CNT_W_DEF = 3;

    localparam logic ROTATE = 1'b1;
    localparam logic SHIFT  = 1'b0;
    localparam logic LEFT   = 1'b1;
    localparam logic RIGHT  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg
// Description : Combinational one-position shift/rotate datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] datain,
    input  logic             mode,
    input  logic             direction,
    input  logic             serial_in,
    output logic [WIDTH-1:0] dataout
);

    always_comb begin
        dataout = datain;
        if (mode == ROTATE) begin
            if (direction == LEFT) dataout = {datain[WIDTH-2:0], datain[WIDTH-1]};
            else                   dataout = {datain[0], datain[WIDTH-1:1]};
        end else begin
            if (direction == LEFT) dataout = {datain[WIDTH-2:0], serial_in};
            else                   dataout = {serial_in, datain[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_ctrl
// Description : Multi-step sequencer driving an external shift_reg once per
//               clock. Optional SHIFT_SEQ_PARITY_EN adds output dout_parity.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [WIDTH-1:0]      din,
    input  logic                  mode,
    input  logic                  direction,
    input  logic [CNT_W-1:0]      count,
    input  logic [2**CNT_W-2:0]   serial_bits,
    output logic [WIDTH-1:0]      sr_datain,
    output logic                  sr_mode,
    output logic                  sr_direction,
    output logic                  sr_serial_in,
    input  logic [WIDTH-1:0]      sr_dataout,
    output logic [WIDTH-1:0]      dout,
`ifdef SHIFT_SEQ_PARITY_EN
    output logic                  dout_parity,
`endif
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] c_ZERO = '0;
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_acc;
    logic [CNT_W-1:0]       r_step;
    logic                   r_mode;
    logic                   r_dir;
    logic [CNT_W-1:0]       r_count;
    logic [2**CNT_W-2:0]    r_serial;
    logic [WIDTH-1:0]       r_dout;
    logic                   r_parity;
    logic                   w_last_step;

    assign start_ready  = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign done_valid   = (r_state == DONE);

    assign sr_datain    = r_acc;
    assign sr_mode      = r_mode;
    assign sr_direction = r_dir;
    assign sr_serial_in = r_serial[r_step];
    assign dout         = r_dout;

    assign w_last_step  = (r_step == (r_count - c_ONE));

`ifdef SHIFT_SEQ_PARITY_EN
    assign dout_parity  = r_parity;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_step   <= '0;
            r_mode   <= 1'b0;
            r_dir    <= 1'b0;
            r_count  <= '0;
            r_serial <= '0;
            r_dout   <= '0;
            r_parity <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_acc    <= din;
                        r_mode   <= mode;
                        r_dir    <= direction;
                        r_count  <= count;
                        r_serial <= serial_bits;
                        r_step   <= '0;
                        // Zero-step command bypasses the datapath entirely
                        if (count == c_ZERO) begin
                            r_dout   <= din;
                            r_parity <= ^din;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_acc <= sr_dataout;
                    if (w_last_step) begin
                        r_dout   <= sr_dataout;
                        r_parity <= ^sr_dataout;
                        r_state  <= DONE;
                    end else begin
                        r_step   <= r_step + c_ONE;
                    end
                end
                DONE: begin
                    if (done_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef SHIFT_SEQ_PARITY_EN
    logic w_unused;
    assign w_unused = r_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_seq_ctrl
// Description : Self-checking bench for shift_seq_ctrl with shift_reg attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [5:0] din = '0;
    logic       mode = 1'b0;
    logic       direction = 1'b0;
    logic [2:0] count = '0;
    logic [6:0] serial_bits = '0;
    logic [5:0] sr_datain;
    logic       sr_mode;
    logic       sr_direction;
    logic       sr_serial_in;
    logic [5:0] sr_dataout;
    logic [5:0] dout;
    logic       done_valid;
    logic       done_ready = 1'b0;
    logic       busy;
`ifdef SHIFT_SEQ_PARITY_EN
    logic       dout_parity;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(6), .CNT_W(3)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .din          (din),
        .mode         (mode),
        .direction    (direction),
        .count        (count),
        .serial_bits  (serial_bits),
        .sr_datain    (sr_datain),
        .sr_mode      (sr_mode),
        .sr_direction (sr_direction),
        .sr_serial_in (sr_serial_in),
        .sr_dataout   (sr_dataout),
        .dout         (dout),
`ifdef SHIFT_SEQ_PARITY_EN
        .dout_parity  (dout_parity),
`endif
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .busy         (busy)
    );

    shift_reg #(.WIDTH(6)) u_sr (
        .datain    (sr_datain),
        .mode      (sr_mode),
        .direction (sr_direction),
        .serial_in (sr_serial_in),
        .dataout   (sr_dataout)
    );

    // Reference: apply c single-position steps with plain arithmetic on 0..63.
    function automatic logic [5:0] model(input logic [5:0] d, input logic m,
                                         input logic dir, input int c,
                                         input logic [6:0] s);
        int v;
        int b;
        v = int'(d);
        for (int i = 0; i < c; i++) begin
            b = int'(s[i]);
            if (m) v = dir ? (v * 2) % 64 + v / 32 : v / 2 + (v % 2) * 32;
            else   v = dir ? (v * 2) % 64 + b      : v / 2 + b * 32;
        end
        return v[5:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [5:0] d, input logic m, input logic dir,
                           input logic [2:0] c, input logic [6:0] s,
                           input int hold, input bit inject,
                           input logic [5:0] exp, input string name);
        start_valid = 1'b1; din = d; mode = m; direction = dir;
        count = c; serial_bits = s;
        tick();
        start_valid = 1'b0; din = $urandom; count = $urandom; serial_bits = $urandom;
        checks++;
        if (start_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: start_ready=%b busy=%b, required 0/1", name, start_ready, busy);
        end
        if (c != 0) begin
            checks++;
            if (sr_mode !== m || sr_direction !== dir) begin
                errors++;
                $display("FAIL %s sr_ctrl: mode=%b dir=%b, required %b/%b", name, sr_mode, sr_direction, m, dir);
            end
        end
        for (int i = 1; i <= int'(c); i++) begin
            checks++;
            if (done_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s latency: done_valid=1 early at cycle %0d of %0d", name, i, c);
            end
            done_ready = 1'($urandom);
            tick();
        end
        done_ready = 1'b0;
        checks++;
        if (done_valid !== 1'b1 || dout !== exp) begin
            errors++;
            $display("FAIL %s result: done_valid=%b dout=%b, required 1/%b", name, done_valid, dout, exp);
        end
`ifdef SHIFT_SEQ_PARITY_EN
        checks++;
        if (dout_parity !== ^exp) begin
            errors++;
            $display("FAIL %s parity: got %b, required %b", name, dout_parity, ^exp);
        end
`endif
        for (int i = 0; i < hold; i++) begin
            if (inject) begin
                start_valid = 1'b1; din = ~d; count = 3'd2;
            end
            tick();
            checks++;
            if (done_valid !== 1'b1 || dout !== exp || start_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold: done_valid=%b dout=%b start_ready=%b, required 1/%b/0",
                         name, done_valid, dout, start_ready, exp);
            end
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        tick();
        done_ready  = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: start_ready=%b done_valid=%b busy=%b, required 1/0/0",
                     name, start_ready, done_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0 ||
            dout !== 6'd0 || sr_datain !== 6'd0) begin
            errors++;
            $display("FAIL reset: start_ready=%b busy=%b done_valid=%b dout=%b acc=%b, required 1/0/0/0/0",
                     start_ready, busy, done_valid, dout, sr_datain);
        end
        din = 6'b111000; count = 3'd3; mode = 1'b1;
        tick(); tick();
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_valid: start_ready=%b busy=%b, required 1/0", start_ready, busy);
        end
    endtask

    task automatic test_directed();
        run_cmd(6'b100001, 1'b1, 1'b1, 3'd1, 7'd0,         0, 1'b0, 6'b000011, "rotl1");
        run_cmd(6'b101100, 1'b1, 1'b0, 3'd6, 7'd0,         0, 1'b0, 6'b101100, "rotr6");
        run_cmd(6'b111111, 1'b0, 1'b0, 3'd3, 7'd0,         0, 1'b0, 6'b000111, "shr3");
        run_cmd(6'b000000, 1'b0, 1'b1, 3'd3, 7'b0000101,   0, 1'b0, 6'b000101, "shl3");
        run_cmd(6'b010101, 1'b1, 1'b1, 3'd0, 7'b1111111,   0, 1'b0, 6'b010101, "pass0");
        run_cmd(6'b100110, 1'b1, 1'b1, 3'd7, 7'd0,         0, 1'b0, 6'b001101, "rotl7");
        run_cmd(6'b000001, 1'b0, 1'b0, 3'd7, 7'b1000001,   0, 1'b0, 6'b100000, "shr7");
    endtask

    task automatic test_backpressure();
        run_cmd(6'b110010, 1'b0, 1'b1, 3'd2, 7'b0000011, 5, 1'b1, 6'b001011, "bp");
        run_cmd(6'b001110, 1'b1, 1'b0, 3'd2, 7'd0,       0, 1'b0, 6'b100011, "bp_next");
    endtask

    task automatic test_reset_midflight();
        start_valid = 1'b1; din = 6'b101011; mode = 1'b1; direction = 1'b1;
        count = 3'd5; serial_bits = 7'd0;
        tick();
        start_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0 || dout !== 6'd0) begin
            errors++;
            $display("FAIL rst_mid: start_ready=%b busy=%b done_valid=%b dout=%b, required 1/0/0/0",
                     start_ready, busy, done_valid, dout);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (done_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_discard: done_valid=%b busy=%b at cycle %0d, required 0/0", done_valid, busy, i);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] d;
        logic       m;
        logic       dir;
        logic [2:0] c;
        logic [6:0] s;
        for (int n = 0; n < 40; n++) begin
            d = $urandom; m = $urandom; dir = $urandom; c = $urandom; s = $urandom;
            run_cmd(d, m, dir, c, s, int'($urandom_range(0, 3)), 1'($urandom),
                    model(d, m, dir, int'(c), s), "rand");
            if ($urandom_range(0, 1) == 1) begin
                din = $urandom; count = $urandom;
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
